// File: rtl/mode_sequencer.sv
// mode_sequencer: steps or directly loads one of NUM_MODES operating modes.
// A switch waits for the active source to drop busy (bounded by DRAIN_MAX),
// mutes display and button routing for BLANK_CYC cycles, then commits the
// new mode. Every output is registered.
module mode_sequencer #(
    parameter int NUM_MODES = 4,
    parameter int MODE_W    = 2,
    parameter int DISP_W    = 32,
    parameter int BLANK_CYC = 4,
    parameter int DRAIN_MAX = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        mode_step,
    input  logic                        mode_load,
    input  logic [MODE_W-1:0]           mode_val,
    input  logic                        busy,
    input  logic                        inc,
    input  logic                        dec,
    input  logic [NUM_MODES*DISP_W-1:0] disp_in,
    output logic [MODE_W-1:0]           model,
    output logic [NUM_MODES-1:0]        mode_onehot,
    output logic                        switching,
    output logic                        mode_chg,
    output logic                        abort,
    output logic [NUM_MODES-1:0]        inc_o,
    output logic [NUM_MODES-1:0]        dec_o,
    output logic [DISP_W-1:0]           disp_o
);

    localparam int DCNT_W = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
    localparam int BCNT_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

    localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_MAX - 1);
    localparam logic [BCNT_W-1:0] BLANK_LAST = BCNT_W'(BLANK_CYC - 1);
    localparam logic [MODE_W-1:0] LAST_MODE  = MODE_W'(NUM_MODES - 1);
    // One bit wider than mode_val so NUM_MODES itself is representable.
    localparam logic [MODE_W:0]   MODE_LIMIT = (MODE_W + 1)'(NUM_MODES);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_BLANK = 2'd2
    } state_t;

    // Sequencer state
    state_t              state_q, state_d;
    logic [MODE_W-1:0]   target_q, target_d;
    logic [DCNT_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic [BCNT_W-1:0]   blank_cnt_q, blank_cnt_d;

    // Registered outputs
    logic [MODE_W-1:0]    model_q, model_d;
    logic [NUM_MODES-1:0] onehot_q, onehot_d;
    logic                 switching_q, switching_d;
    logic                 mode_chg_q, mode_chg_d;
    logic                 abort_q, abort_d;
    logic [NUM_MODES-1:0] inc_q, inc_d;
    logic [NUM_MODES-1:0] dec_q, dec_d;
    logic [DISP_W-1:0]    disp_q, disp_d;

    // Request decode and helpers
    logic                 load_ok;
    logic                 req_accept;
    logic [MODE_W-1:0]    next_mode;
    logic [MODE_W-1:0]    req_target;
    logic                 drain_timeout;
    logic                 blank_done;
    logic                 route_ok;
    logic [DISP_W-1:0]    disp_sel;

    function automatic logic [NUM_MODES-1:0] decode(input logic [MODE_W-1:0] m);
        logic [NUM_MODES-1:0] oh;
        oh = '0;
        for (int unsigned i = 0; i < NUM_MODES; i++) begin
            if (m == MODE_W'(i)) begin
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

    // Classify the incoming mode request; a load always shadows a step.
    always_comb begin
        next_mode     = (model_q == LAST_MODE) ? '0 : model_q + 1'b1;
        load_ok       = mode_load && ({1'b0, mode_val} < MODE_LIMIT);
        req_accept    = (state_q == S_RUN) && (load_ok || (mode_step && !mode_load));
        req_target    = load_ok ? mode_val : next_mode;
        drain_timeout = (state_q == S_DRAIN) && busy && (drain_cnt_q == DRAIN_LAST);
        blank_done    = (state_q == S_BLANK) && (blank_cnt_q == BLANK_LAST);
        route_ok      = (state_q == S_RUN) && !mode_step && !mode_load;
    end

    // Select the display word of the committed mode.
    always_comb begin
        disp_sel = '0;
        for (int unsigned m = 0; m < NUM_MODES; m++) begin
            if (model_q == MODE_W'(m)) begin
                disp_sel = disp_in[m*DISP_W +: DISP_W];
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_RUN;
            target_q    <= '0;
            drain_cnt_q <= '0;
            blank_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            drain_cnt_q <= drain_cnt_d;
            blank_cnt_q <= blank_cnt_d;
        end
    end

    // Next-state logic: RUN accepts requests, DRAIN waits for idle, BLANK times the guard.
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        drain_cnt_d = drain_cnt_q;
        blank_cnt_d = blank_cnt_q;
        unique case (state_q)
            S_RUN: begin
                drain_cnt_d = '0;
                blank_cnt_d = '0;
                if (req_accept) begin
                    state_d  = S_DRAIN;
                    target_d = req_target;
                end
            end
            S_DRAIN: begin
                if (!busy) begin
                    state_d     = S_BLANK;
                    blank_cnt_d = '0;
                end else if (drain_timeout) begin
                    state_d     = S_RUN;
                    drain_cnt_d = '0;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            S_BLANK: begin
                if (blank_done) begin
                    state_d     = S_RUN;
                    blank_cnt_d = '0;
                end else begin
                    blank_cnt_d = blank_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // Output logic: commit, status pulses, button routing and display muting.
    always_comb begin
        model_d     = model_q;
        mode_chg_d  = 1'b0;
        abort_d     = drain_timeout;
        if (blank_done) begin
            model_d    = target_q;
            mode_chg_d = 1'b1;
        end
        onehot_d    = decode(model_d);
        switching_d = (state_d != S_RUN);
        inc_d       = (route_ok && inc && !dec) ? onehot_q : '0;
        dec_d       = (route_ok && dec && !inc) ? onehot_q : '0;
        disp_d      = (state_q == S_RUN) ? disp_sel : '0;
    end

    // Output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            model_q     <= '0;
            onehot_q    <= NUM_MODES'(1);
            switching_q <= 1'b0;
            mode_chg_q  <= 1'b0;
            abort_q     <= 1'b0;
            inc_q       <= '0;
            dec_q       <= '0;
            disp_q      <= '0;
        end else begin
            model_q     <= model_d;
            onehot_q    <= onehot_d;
            switching_q <= switching_d;
            mode_chg_q  <= mode_chg_d;
            abort_q     <= abort_d;
            inc_q       <= inc_d;
            dec_q       <= dec_d;
            disp_q      <= disp_d;
        end
    end

    assign model       = model_q;
    assign mode_onehot = onehot_q;
    assign switching   = switching_q;
    assign mode_chg    = mode_chg_q;
    assign abort       = abort_q;
    assign inc_o       = inc_q;
    assign dec_o       = dec_q;
    assign disp_o      = disp_q;

endmodule

// File: tb/tb_mode_sequencer.sv
// tb_mode_sequencer: two instances (4 modes / 3 modes) share one stimulus
// stream; a per-cycle behavioural model predicts every output of both.
module tb_mode_sequencer;

    localparam int DW  = 32;
    localparam int DM  = 16;
    localparam int N0  = 4;
    localparam int N1  = 3;
    localparam int BC0 = 4;
    localparam int BC1 = 2;

    logic            clk       = 1'b0;
    logic            rst_n     = 1'b0;
    logic            mode_step = 1'b0;
    logic            mode_load = 1'b0;
    logic [1:0]      mode_val  = 2'd0;
    logic            busy      = 1'b0;
    logic            inc       = 1'b0;
    logic            dec       = 1'b0;
    logic [N0*DW-1:0] disp_in  = '0;

    logic [1:0]  model0, model1;
    logic [3:0]  oh0, inc_o0, dec_o0;
    logic [2:0]  oh1, inc_o1, dec_o1;
    logic        sw0, sw1, chg0, chg1, abort0, abort1;
    logic [31:0] disp_o0, disp_o1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mode_sequencer #(.NUM_MODES(N0), .MODE_W(2), .DISP_W(DW), .BLANK_CYC(BC0), .DRAIN_MAX(DM)) dut0 (
        .clk(clk), .rst_n(rst_n), .mode_step(mode_step), .mode_load(mode_load),
        .mode_val(mode_val), .busy(busy), .inc(inc), .dec(dec), .disp_in(disp_in),
        .model(model0), .mode_onehot(oh0), .switching(sw0), .mode_chg(chg0),
        .abort(abort0), .inc_o(inc_o0), .dec_o(dec_o0), .disp_o(disp_o0)
    );

    mode_sequencer #(.NUM_MODES(N1), .MODE_W(2), .DISP_W(DW), .BLANK_CYC(BC1), .DRAIN_MAX(DM)) dut1 (
        .clk(clk), .rst_n(rst_n), .mode_step(mode_step), .mode_load(mode_load),
        .mode_val(mode_val), .busy(busy), .inc(inc), .dec(dec), .disp_in(disp_in[N1*DW-1:0]),
        .model(model1), .mode_onehot(oh1), .switching(sw1), .mode_chg(chg1),
        .abort(abort1), .inc_o(inc_o1), .dec_o(dec_o1), .disp_o(disp_o1)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a switch is "draining" (counting busy cycles) or
    // "blanking" (cycles left); otherwise the sequencer is running.
    int  n_modes [2] = '{N0, N1};
    int  n_blank [2] = '{BC0, BC1};
    int  m_model [2];
    int  m_target [2];
    int  m_busy_cnt [2];
    int  m_blank_left [2];
    bit  m_draining [2];
    int  e_model [2];
    bit  e_chg [2];
    bit  e_abort [2];
    bit  e_sw [2];
    int  e_inc [2];
    int  e_dec [2];
    logic [31:0] e_disp [2];
    bit  chk_en = 1'b0;

    always @(posedge clk) begin
        bit running;
        bit clean;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_model[i] = 0; m_target[i] = 0; m_busy_cnt[i] = 0;
                m_blank_left[i] = 0; m_draining[i] = 1'b0;
                e_model[i] = 0; e_chg[i] = 1'b0; e_abort[i] = 1'b0; e_sw[i] = 1'b0;
                e_inc[i] = 0; e_dec[i] = 0; e_disp[i] = 32'h0;
            end else begin
                running    = !m_draining[i] && (m_blank_left[i] == 0);
                clean      = running && !mode_step && !mode_load;
                e_inc[i]   = (clean && inc && !dec) ? (1 << m_model[i]) : 0;
                e_dec[i]   = (clean && dec && !inc) ? (1 << m_model[i]) : 0;
                e_disp[i]  = running ? disp_in[m_model[i]*DW +: DW] : 32'h0;
                e_chg[i]   = 1'b0;
                e_abort[i] = 1'b0;
                if (running) begin
                    if (mode_load) begin
                        if (int'(mode_val) < n_modes[i]) begin
                            m_target[i] = int'(mode_val);
                            m_draining[i] = 1'b1;
                            m_busy_cnt[i] = 0;
                        end
                    end else if (mode_step) begin
                        m_target[i] = (m_model[i] + 1) % n_modes[i];
                        m_draining[i] = 1'b1;
                        m_busy_cnt[i] = 0;
                    end
                end else if (m_draining[i]) begin
                    if (!busy) begin
                        m_draining[i] = 1'b0;
                        m_blank_left[i] = n_blank[i];
                    end else begin
                        m_busy_cnt[i]++;
                        if (m_busy_cnt[i] == DM) begin
                            m_draining[i] = 1'b0;
                            e_abort[i] = 1'b1;
                        end
                    end
                end else begin
                    m_blank_left[i]--;
                    if (m_blank_left[i] == 0) begin
                        m_model[i] = m_target[i];
                        e_chg[i] = 1'b1;
                    end
                end
                e_model[i] = m_model[i];
                e_sw[i]    = m_draining[i] || (m_blank_left[i] > 0);
            end
        end
        if (!rst_n) chk_en = 1'b1;
    end

    // Compare every output of both instances against the model each cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model0",  32'(model0),  32'(e_model[0]));
            check("onehot0", 32'(oh0),     32'(1 << e_model[0]));
            check("sw0",     32'(sw0),     32'(e_sw[0]));
            check("chg0",    32'(chg0),    32'(e_chg[0]));
            check("abort0",  32'(abort0),  32'(e_abort[0]));
            check("inc_o0",  32'(inc_o0),  32'(e_inc[0]));
            check("dec_o0",  32'(dec_o0),  32'(e_dec[0]));
            check("disp_o0", disp_o0,      e_disp[0]);
            check("model1",  32'(model1),  32'(e_model[1]));
            check("onehot1", 32'(oh1),     32'(1 << e_model[1]));
            check("sw1",     32'(sw1),     32'(e_sw[1]));
            check("chg1",    32'(chg1),    32'(e_chg[1]));
            check("abort1",  32'(abort1),  32'(e_abort[1]));
            check("inc_o1",  32'(inc_o1),  32'(e_inc[1]));
            check("dec_o1",  32'(dec_o1),  32'(e_dec[1]));
            check("disp_o1", disp_o1,      e_disp[1]);
        end
    end

    // Pulse a request for one cycle; returns in the cycle after the request.
    task automatic start_req(input logic st, input logic ld, input logic [1:0] v, input logic b);
        @(negedge clk);
        mode_step = st; mode_load = ld; mode_val = v; busy = b;
        @(negedge clk);
        mode_step = 1'b0; mode_load = 1'b0;
    endtask

    // Count cycles since the request until dut0 pulses mode_chg; busy is
    // held high for the first nbusy cycles after the request.
    task automatic wait_chg(input int nbusy, input int start, output int lat);
        lat = start;
        while (!chg0 && lat < 200) begin
            busy = (lat <= nbusy);
            @(negedge clk);
            lat++;
        end
        busy = 1'b0;
        if (!chg0) lat = -1;
    endtask

    initial begin
        int lat;
        int seen;
        int wrap_exp [5];
        wrap_exp = '{1, 2, 3, 0, 1};
        disp_in = {32'h4444_0003, 32'h3333_0002, 32'h0000_ABCD, 32'h1111_0000};

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_model",  32'(model0), 32'd0);
        check("rst_onehot", 32'(oh0),    32'd1);
        check("rst_sw",     32'(sw0),    32'd0);
        check("rst_disp",   disp_o0,     32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("run_disp", disp_o0, 32'h1111_0000);

        // Wrap-around
        for (int j = 0; j < 5; j++) begin
            start_req(1'b1, 1'b0, 2'd0, 1'b0);
            wait_chg(0, 1, lat);
            check("wrap_lat", 32'(lat), 32'd6);
            check("wrap_model", 32'(model0), 32'(wrap_exp[j]));
            @(negedge clk);
            check("chg_single", 32'(chg0), 32'd0);
            repeat (7) @(negedge clk);
        end

        // Busy defer from mode 2
        start_req(1'b0, 1'b1, 2'd2, 1'b0);
        wait_chg(0, 1, lat);
        check("load2_model", 32'(model0), 32'd2);
        start_req(1'b1, 1'b0, 2'd0, 1'b1);
        wait_chg(10, 1, lat);
        check("busy_lat", 32'(lat), 32'd16);
        check("busy_model", 32'(model0), 32'd3);

        // Drain timeout
        start_req(1'b1, 1'b0, 2'd0, 1'b1);
        lat = 1;
        while (!abort0 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("abort_lat", 32'(lat), 32'd17);
        check("abort_model", 32'(model0), 32'd3);
        busy = 1'b0;
        @(negedge clk);
        check("abort_single", 32'(abort0), 32'd0);
        start_req(1'b1, 1'b0, 2'd0, 1'b0);
        wait_chg(0, 1, lat);
        check("after_abort_lat", 32'(lat), 32'd6);
        check("after_abort_model", 32'(model0), 32'd0);

        // Direct loads
        start_req(1'b0, 1'b1, 2'd2, 1'b0);
        wait_chg(0, 1, lat);
        check("load_model", 32'(model0), 32'd2);
        start_req(1'b0, 1'b1, 2'd3, 1'b0);
        check("illegal_ignored_sw1", 32'(sw1), 32'd0);
        check("legal_accepted_sw0", 32'(sw0), 32'd1);
        wait_chg(0, 1, lat);
        check("load3_model", 32'(model0), 32'd3);
        start_req(1'b1, 1'b1, 2'd1, 1'b0);
        wait_chg(0, 1, lat);
        check("load_wins_model", 32'(model0), 32'd1);
        repeat (2) @(negedge clk);

        // Routing in mode 1
        inc = 1'b1;
        @(negedge clk);
        inc = 1'b0;
        check("inc_route", 32'(inc_o0), 32'h2);
        @(negedge clk);
        check("inc_width", 32'(inc_o0), 32'h0);
        inc = 1'b1; dec = 1'b1;
        @(negedge clk);
        inc = 1'b0; dec = 1'b0;
        check("both_inc", 32'(inc_o0), 32'h0);
        check("both_dec", 32'(dec_o0), 32'h0);
        dec = 1'b1;
        @(negedge clk);
        dec = 1'b0;
        check("dec_route", 32'(dec_o0), 32'h2);

        // Re-initialise mode 1 and watch the display blanking
        start_req(1'b0, 1'b1, 2'd1, 1'b0);
        wait_chg(0, 1, lat);
        check("reinit_lat", 32'(lat), 32'd6);
        check("reinit_disp_first", disp_o0, 32'h0);
        @(negedge clk);
        check("reinit_disp_second", disp_o0, 32'h0000_ABCD);

        // inc during BLANK is dropped
        start_req(1'b1, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        inc = 1'b1;
        @(negedge clk);
        inc = 1'b0;
        check("blank_inc", 32'(inc_o0), 32'h0);
        wait_chg(0, 3, lat);
        check("blank_lat", 32'(lat), 32'd6);
        check("blank_model", 32'(model0), 32'd2);
        repeat (2) @(negedge clk);

        // Reset mid-switch
        start_req(1'b1, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rstmid_model", 32'(model0), 32'd0);
        check("rstmid_sw", 32'(sw0), 32'd0);
        check("rstmid_chg", 32'(chg0), 32'd0);
        check("rstmid_onehot", 32'(oh0), 32'd1);
        rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (chg0) seen++;
        end
        check("rstmid_no_chg", 32'(seen), 32'd0);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            mode_step = ($urandom_range(0, 11) == 0);
            mode_load = ($urandom_range(0, 15) == 0);
            mode_val  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) busy = ~busy;
            inc   = ($urandom_range(0, 3) == 0);
            dec   = ($urandom_range(0, 3) == 0);
            rst_n = ($urandom_range(0, 599) != 0);
            if (c % 16 == 0) disp_in = {$urandom, $urandom, $urandom, $urandom};
        end
        @(negedge clk);
        mode_step = 1'b0; mode_load = 1'b0; inc = 1'b0; dec = 1'b0; rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
